// File: rtl/uart_prog_loader_pkg.sv
// rtl/uart_prog_loader_pkg.sv - shared RX state encoding and baud constant for the program loader
package uart_prog_loader_pkg;

    localparam int CLKS_PER_BIT_115200 = 434;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_BREAK
    } rx_state_t;

endpackage

// File: rtl/uart_prog_loader_rx_byte.sv
// rtl/uart_prog_loader_rx_byte.sv - 8N1 receiver: synchronizer, bit timer, shift register
module uart_rx_byte
    import uart_prog_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       framing_err,
    output logic       start_ok
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] FULL_LAST = TW'(CLKS_PER_BIT - 1);

    rx_state_t       state, state_n;
    logic [TW-1:0]   timer, timer_n;
    logic [2:0]      bit_idx, bit_n;
    logic [7:0]      shift, shift_n;
    logic            rx_meta, rx_s;
    logic            valid_n, ferr_n, start_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta     <= 1'b1;
            rx_s        <= 1'b1;
            state       <= RX_IDLE;
            timer       <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            byte_valid  <= 1'b0;
            framing_err <= 1'b0;
            start_ok    <= 1'b0;
        end else begin
            rx_meta     <= rx;
            rx_s        <= rx_meta;
            state       <= state_n;
            timer       <= timer_n;
            bit_idx     <= bit_n;
            shift       <= shift_n;
            byte_valid  <= valid_n;
            framing_err <= ferr_n;
            start_ok    <= start_n;
        end
    end

    always_comb begin
        state_n = state;
        timer_n = timer + 1'b1;
        bit_n   = bit_idx;
        shift_n = shift;
        valid_n = 1'b0;
        ferr_n  = 1'b0;
        start_n = 1'b0;
        case (state)
            RX_IDLE: begin
                timer_n = '0;
                if (!rx_s) state_n = RX_START;
            end
            RX_START: begin
                // Mid-start-bit check rejects short glitches on the line
                if (timer == HALF_LAST) begin
                    timer_n = '0;
                    bit_n   = '0;
                    if (rx_s) begin
                        state_n = RX_IDLE;
                    end else begin
                        state_n = RX_DATA;
                        start_n = 1'b1;
                    end
                end
            end
            RX_DATA: begin
                if (timer == FULL_LAST) begin
                    timer_n = '0;
                    shift_n = {rx_s, shift[7:1]};
                    bit_n   = bit_idx + 1'b1;
                    if (bit_idx == 3'd7) state_n = RX_STOP;
                end
            end
            RX_STOP: begin
                if (timer == FULL_LAST) begin
                    timer_n = '0;
                    if (rx_s) begin
                        valid_n = 1'b1;
                        state_n = RX_IDLE;
                    end else begin
                        ferr_n  = 1'b1;
                        state_n = RX_BREAK;
                    end
                end
            end
            RX_BREAK: begin
                timer_n = '0;
                if (rx_s) state_n = RX_IDLE;
            end
            default: begin
                timer_n = '0;
                state_n = RX_IDLE;
            end
        endcase
    end

    assign byte_data = shift;

endmodule

// File: rtl/uart_prog_loader.sv
// rtl/uart_prog_loader.sv - pairs UART bytes into 16-bit words with auto-incrementing write address
module uart_prog_loader
    import uart_prog_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_115200,
    parameter int ADDR_W       = 16,
    parameter int TIMEOUT_CLKS = 5000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    output logic [15:0]       prog_data,
    output logic [ADDR_W-1:0] prog_addr,
    output logic              prog_we,
    output logic              byte_cnt,
    output logic              framing_err,
    output logic              loading
);

    localparam int TOW = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TOW-1:0] TO_LAST = TOW'(TIMEOUT_CLKS - 1);

    logic           byte_valid;
    logic [7:0]     byte_data;
    logic           start_ok;
    logic [7:0]     hi;
    logic [TOW-1:0] to_cnt;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .framing_err(framing_err),
        .start_ok   (start_ok)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prog_data <= '0;
            prog_addr <= '0;
            prog_we   <= 1'b0;
            byte_cnt  <= 1'b0;
            loading   <= 1'b0;
            hi        <= '0;
            to_cnt    <= '0;
        end else begin
            prog_we <= 1'b0;
            // Address advances as the strobe drops, so it is stable for the whole strobe
            if (prog_we) prog_addr <= prog_addr + 1'b1;

            if (start_ok) begin
                loading <= 1'b1;
                to_cnt  <= '0;
            end else if (loading) begin
                if (to_cnt == TO_LAST) begin
                    loading  <= 1'b0;
                    byte_cnt <= 1'b0;
                    to_cnt   <= '0;
                end else begin
                    to_cnt <= to_cnt + 1'b1;
                end
            end

            if (framing_err) begin
                byte_cnt <= 1'b0;
            end else if (byte_valid) begin
                to_cnt <= '0;
                if (!byte_cnt) begin
                    hi       <= byte_data;
                    byte_cnt <= 1'b1;
                end else begin
                    prog_data <= {hi, byte_data};
                    prog_we   <= 1'b1;
                    byte_cnt  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_prog_loader.sv
// tb/tb_uart_prog_loader.sv - directed self-checking bench for uart_prog_loader
module tb_uart_prog_loader;

    localparam int CPB = 8;
    localparam int AW  = 2;
    localparam int TO  = 100;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx  = 1'b1;
    logic [15:0]   prog_data;
    logic [AW-1:0] prog_addr;
    logic          prog_we;
    logic          byte_cnt;
    logic          framing_err;
    logic          loading;

    int n_asserts = 0;
    int n_fail    = 0;
    int we_cnt    = 0;
    int ferr_cnt  = 0;
    int we_long   = 0;
    logic          we_prev = 1'b0;
    logic [15:0]   we_data [64];
    logic [AW-1:0] we_addr [64];
    int base;

    uart_prog_loader #(
        .CLKS_PER_BIT(CPB),
        .ADDR_W      (AW),
        .TIMEOUT_CLKS(TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .prog_data  (prog_data),
        .prog_addr  (prog_addr),
        .prog_we    (prog_we),
        .byte_cnt   (byte_cnt),
        .framing_err(framing_err),
        .loading    (loading)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (prog_we) begin
            if (we_cnt < 64) begin
                we_data[we_cnt] = prog_data;
                we_addr[we_cnt] = prog_addr;
            end
            we_cnt++;
            if (we_prev) we_long++;
        end
        if (framing_err) ferr_cnt++;
        we_prev = prog_we;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic rx_bit(input logic v);
        @(posedge clk);
        #1 rx = v;
        repeat (CPB - 1) @(posedge clk);
    endtask

    task automatic idle(input int n);
        @(posedge clk);
        #1 rx = 1'b1;
        repeat (n - 1) @(posedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx_bit(1'b0);
        for (int i = 0; i < 8; i++) rx_bit(b[i]);
        rx_bit(stop);
    endtask

    task automatic send_word(input logic [15:0] w);
        send_byte(w[15:8], 1'b1);
        send_byte(w[7:0], 1'b1);
        idle(4);
    endtask

    task automatic do_reset;
        @(posedge clk);
        #1 rst = 1'b1;
        rx = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        idle(4);
    endtask

    task automatic check_outputs_zero(input string tag);
        @(negedge clk);
        check({tag, "_data"},  32'(prog_data),   32'h0);
        check({tag, "_addr"},  32'(prog_addr),   32'h0);
        check({tag, "_we"},    32'(prog_we),     32'h0);
        check({tag, "_bcnt"},  32'(byte_cnt),    32'h0);
        check({tag, "_ferr"},  32'(framing_err), 32'h0);
        check({tag, "_load"},  32'(loading),     32'h0);
    endtask

    initial begin
        // reset state
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst = 1'b0;
        idle(4);

        // 0x12,0x34 -> one word at addr 0
        base = we_cnt;
        send_byte(8'h12, 1'b1);
        idle(2);
        @(negedge clk);
        check("t1_bcnt_mid", 32'(byte_cnt), 32'h1);
        check("t1_loading",  32'(loading),  32'h1);
        send_byte(8'h34, 1'b1);
        idle(4);
        check("t1_n_we", 32'(we_cnt - base), 32'd1);
        check("t1_data", 32'(we_data[base]), 32'h1234);
        check("t1_addr", 32'(we_addr[base]), 32'h0);
        @(negedge clk);
        check("t1_addr_after", 32'(prog_addr), 32'h1);
        check("t1_bcnt_after", 32'(byte_cnt),  32'h0);
        check("t1_hold_data",  32'(prog_data), 32'h1234);

        // four bytes -> two words
        do_reset();
        base = we_cnt;
        send_word(16'hABCD);
        send_word(16'h00FF);
        check("t2_n_we",  32'(we_cnt - base),     32'd2);
        check("t2_data0", 32'(we_data[base]),     32'hABCD);
        check("t2_addr0", 32'(we_addr[base]),     32'h0);
        check("t2_data1", 32'(we_data[base + 1]), 32'h00FF);
        check("t2_addr1", 32'(we_addr[base + 1]), 32'h1);

        // 2-cycle glitch is ignored
        do_reset();
        base = we_cnt;
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (2) @(posedge clk);
        #1 rx = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("t3_glitch_we",   32'(we_cnt - base), 32'd0);
        check("t3_glitch_ferr", 32'(ferr_cnt),      32'd0);
        check("t3_glitch_bcnt", 32'(byte_cnt),      32'h0);
        check("t3_glitch_load", 32'(loading),       32'h0);
        send_word(16'h55AA);
        check("t3_n_we", 32'(we_cnt - base), 32'd1);
        check("t3_data", 32'(we_data[base]), 32'h55AA);
        check("t3_addr", 32'(we_addr[base]), 32'h0);

        // framing error, line held low, then recovery
        do_reset();
        base = we_cnt;
        send_byte(8'hC3, 1'b0);
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (40) @(posedge clk);
        idle(16);
        check("t4_ferr_cnt", 32'(ferr_cnt), 32'd1);
        check("t4_bcnt",     32'(byte_cnt), 32'h0);
        send_word(16'h0102);
        check("t4_ferr_cnt_end", 32'(ferr_cnt),       32'd1);
        check("t4_n_we",         32'(we_cnt - base),  32'd1);
        check("t4_data",         32'(we_data[base]),  32'h0102);
        check("t4_addr",         32'(we_addr[base]),  32'h0);

        // framing error on second byte drops the held high byte
        do_reset();
        base = we_cnt;
        send_byte(8'h9A, 1'b1);
        send_byte(8'hBC, 1'b0);
        idle(16);
        check("t4b_n_we", 32'(we_cnt - base), 32'd0);
        check("t4b_bcnt", 32'(byte_cnt),      32'h0);
        send_word(16'h3344);
        check("t4b_data", 32'(we_data[base]), 32'h3344);
        check("t4b_addr", 32'(we_addr[base]), 32'h0);

        // timeout discards a lone byte
        do_reset();
        base = we_cnt;
        send_byte(8'h77, 1'b1);
        idle(150);
        @(negedge clk);
        check("t5_n_we", 32'(we_cnt - base), 32'd0);
        check("t5_bcnt", 32'(byte_cnt),      32'h0);
        check("t5_load", 32'(loading),       32'h0);
        send_word(16'h1122);
        check("t5_n_we_end", 32'(we_cnt - base), 32'd1);
        check("t5_data",     32'(we_data[base]), 32'h1122);
        check("t5_addr",     32'(we_addr[base]), 32'h0);

        // address wrap, then reset in the middle of the sixth word
        do_reset();
        base = we_cnt;
        send_word(16'h1001);
        send_word(16'h2002);
        send_word(16'h3003);
        send_word(16'h4004);
        send_word(16'h5005);
        check("t6_n_we",  32'(we_cnt - base),     32'd5);
        check("t6_addr3", 32'(we_addr[base + 3]), 32'h3);
        check("t6_addr4", 32'(we_addr[base + 4]), 32'h0);
        check("t6_data4", 32'(we_data[base + 4]), 32'h5005);
        @(negedge clk);
        check("t6_addr_now", 32'(prog_addr), 32'h1);
        send_byte(8'h66, 1'b1);
        rx_bit(1'b0);
        rx_bit(1'b1);
        rx_bit(1'b0);
        #1 rst = 1'b1;
        check_outputs_zero("t6_rst");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        rx = 1'b1;
        idle(4);
        base = we_cnt;
        send_word(16'hBEEF);
        check("t6_n_we_post", 32'(we_cnt - base), 32'd1);
        check("t6_data_post", 32'(we_data[base]), 32'hBEEF);
        check("t6_addr_post", 32'(we_addr[base]), 32'h0);

        check("we_one_cycle", 32'(we_long), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_prog_loader.md
Name: uart_prog_loader

Overview:
Upstream stage of the program-load path. Receives 8N1 serial bytes from the Bluetooth module on a GPIO pin and assembles byte pairs into 16-bit instruction words. Each completed word is presented with a write address and a one-cycle write strobe for the CPU's instruction memory. It replaces the ad-hoc address counter in the top level, so the address is generated inside the block.

Parameters:
CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200); must be >= 4
ADDR_W, 16, width of the program address counter
TIMEOUT_CLKS, 5000000, idle clocks after a lone first byte before it is discarded (100 ms)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
rx  input  1  raw UART line from GPIO; asynchronous; idle high
prog_data  output  16  assembled word, {first byte, second byte}
prog_addr  output  ADDR_W  instruction-memory address for prog_data
prog_we  output  1  one-cycle write strobe; prog_data and prog_addr are valid while it is high
byte_cnt  output  1  0 = expecting the high byte; 1 = high byte held, expecting the low byte
framing_err  output  1  one-cycle pulse when a stop bit samples low
loading  output  1  high from the first accepted start bit until a timeout expires

Behaviour:
- Interface (already decided): one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: prog_data=0, prog_addr=0, prog_we=0, byte_cnt=0, framing_err=0, loading=0. The FSM is in IDLE and both synchronizer flops are 1.
- rx passes through a 2-flop synchronizer (rx_s) reset to 1. All sampling below uses rx_s.
- RX FSM states and transitions:
  - IDLE: on rx_s==0, go to START and clear the bit timer.
  - START: wait CLKS_PER_BIT/2 cycles (integer division), then sample rx_s.
    - If 1, treat it as a glitch: return to IDLE with no output.
    - If 0, go to DATA.
  - DATA: every CLKS_PER_BIT cycles sample one bit into the shift register, LSB first. After 8 samples go to STOP.
  - STOP: after CLKS_PER_BIT cycles sample rx_s.
    - If 1, the byte is accepted.
    - If 0, pulse framing_err, drop the byte, force byte_cnt=0, and go to BREAK.
  - BREAK: stay until rx_s==1, then go to IDLE. This prevents a held-low line from creating phantom starts.
  - Accepted byte: return to IDLE in the same cycle as the stop sample.
- Word assembly, on the cycle after a byte is accepted:
  - byte_cnt==0: latch the byte as hi, set byte_cnt=1, start the timeout counter.
  - byte_cnt==1: set prog_data={hi, byte}, prog_we=1 for exactly one cycle, and byte_cnt=0. prog_addr holds the current address during the strobe.
  - prog_addr increments on the cycle after prog_we falls.
- Latency: prog_we rises 2 cycles after the second byte's stop-bit sample. Add 2 cycles of synchronizer delay relative to raw rx.
- Address wrap: from 2^ADDR_W-1, prog_addr increments to 0 with no flag.
- Timeout:
  - While byte_cnt==1 the counter runs. It resets on every accepted start bit.
  - When it reaches TIMEOUT_CLKS, clear byte_cnt and discard the held byte. No strobe is issued.
  - loading falls on that same timeout, and also on any TIMEOUT_CLKS-long idle with byte_cnt==0.
  - prog_addr is not reset by timeout; only rst clears it.
- Simultaneous events: a framing error on the second byte clears byte_cnt with no strobe, and the held hi byte is lost.
- Reset mid-byte: all state is cleared immediately, and the partial byte and held hi byte are lost. After rst falls, the first falling edge of rx_s starts a fresh frame.
- prog_data holds its last value between strobes.

Decomposition:
- Shared package: RX state encoding (IDLE, START, DATA, STOP, BREAK) and the default-baud constant CLKS_PER_BIT_115200=434.
- One natural sub-module, uart_rx_byte. It contains the synchronizer, FSM, bit timer and shift register, and outputs byte_valid/byte_data/framing_err.
- The parent holds word assembly, timeout, address counter and loading.

Test Plan:
- Send 0x12 then 0x34 at CLKS_PER_BIT=8 -> one prog_we pulse with prog_data=0x1234, prog_addr=0. Then prog_addr=1, byte_cnt=0.
- Send 0xAB,0xCD,0x00,0xFF -> two strobes: 0xABCD at addr 0 and 0x00FF at addr 1.
- Send a 2-cycle low glitch on rx -> no byte, no framing_err, FSM back in IDLE. A following 0x55,0xAA yields 0x55AA at addr 0.
- Send a byte with stop bit = 0, then hold rx low 40 cycles, then send 0x01,0x02 -> framing_err pulses once, then one strobe of 0x0102 at addr 0.
- TIMEOUT_CLKS=100: send 0x77, wait 150 cycles, send 0x11,0x22 -> no strobe for 0x77, byte_cnt cleared, then 0x1122 at addr 0.
- ADDR_W=2: send 5 words, asserting rst in the middle of the sixth -> addresses 0,1,2,3,0. After reset every output is 0 and the next word lands at addr 0.
